// File: rtl/timer_counter.sv
// timer_counter: a start/stop counter driven by a push button.
// BTN is synchronised and edge-detected; each press toggles the machine
// between RUN and PAUSE (the first press leaves IDLE). While in RUN a
// prescaler divides CLK by DIV, and each prescaler tick advances the 4-bit
// count Q through 0..MAX, wrapping back to 0 with a one-cycle CARRY pulse.
//
// Handshake note: there is no valid/ready traffic here. The only event
// interface is the internal one-cycle edge pulse w_edge, which is consumed
// by the state machine on the same CLK edge on which it is high; it is
// never queued, so a pulse that lands together with CLR is simply lost.
module timer_counter #(
  parameter int DIV = 4,
  parameter int MAX = 9
) (
  input  logic       CLK,
  input  logic       XRST,
  input  logic       BTN,
  input  logic       CLR,
  output logic [3:0] Q,
  output logic       CARRY,
  output logic       RUNNING,
  output logic [1:0] o_dbg_state
);

  localparam int              DW       = $clog2(DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]      Q_MAX    = 4'(MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_sync2_d;
  logic          w_edge;
  logic          w_tick;
  logic [DW-1:0] r_div;
  logic [3:0]    r_q;
  logic          r_carry;

  // Two-flop synchroniser plus the edge register. CLR deliberately leaves
  // these alone so that a button held across a clear does not re-trigger.
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
    end else begin
      r_sync1   <= BTN;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  // One pulse per rising level of the synchronised button.
  assign w_edge = r_sync2 & ~r_sync2_d;

  // Prescaler terminal count, only meaningful while running.
  assign w_tick = (r_state == ST_RUN) && (r_div == DIV_LAST);

  // Next-state logic: CLR wins over any button edge.
  always_comb begin
    w_state_next = r_state;
    if (CLR) begin
      w_state_next = ST_IDLE;
    end else if (w_edge) begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_RUN;
        ST_RUN:   w_state_next = ST_PAUSE;
        ST_PAUSE: w_state_next = ST_RUN;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Prescaler: counts in RUN, holds in PAUSE so a resume keeps its phase.
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      r_div <= '0;
    end else if (CLR) begin
      r_div <= '0;
    end else begin
      case (r_state)
        ST_RUN:   r_div <= w_tick ? '0 : r_div + DW'(1);
        ST_PAUSE: r_div <= r_div;
        default:  r_div <= '0;
      endcase
    end
  end

  // Count and carry: a tick still lands even if the same edge pauses.
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      r_q     <= 4'd0;
      r_carry <= 1'b0;
    end else if (CLR) begin
      r_q     <= 4'd0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_tick && (r_q == Q_MAX);
      if (w_tick) begin
        r_q <= (r_q == Q_MAX) ? 4'd0 : r_q + 4'd1;
      end
    end
  end

  assign Q           = r_q;
  assign CARRY       = r_carry;
  assign RUNNING     = (r_state == ST_RUN);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter with DIV=4, MAX=9.
// Inputs change on the falling edge; outputs are sampled on the falling
// edge. "Pn" in the comments is the n-th rising edge of the current phase.
module tb_timer_counter;

  logic       CLK;
  logic       XRST;
  logic       BTN;
  logic       CLR;
  logic [3:0] Q;
  logic       CARRY;
  logic       RUNNING;
  logic [1:0] o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  timer_counter #(.DIV(4), .MAX(9)) dut (
    .CLK         (CLK),
    .XRST        (XRST),
    .BTN         (BTN),
    .CLR         (CLR),
    .Q           (Q),
    .CARRY       (CARRY),
    .RUNNING     (RUNNING),
    .o_dbg_state (o_dbg_state)
  );

  // Clock and watchdog.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    int carries;
    int rises;
    int q_changes;
    logic       prev_run;
    logic [3:0] prev_q;

    XRST = 1'b0;
    BTN  = 1'b0;
    CLR  = 1'b0;
    #1;
    check("reset_q", 32'(Q), 0);
    check("reset_carry", 32'(CARRY), 0);
    check("reset_running", 32'(RUNNING), 0);
    check("reset_state", 32'(o_dbg_state), 0);
    wait_n(2);
    XRST = 1'b1;
    wait_n(2);
    check("idle_after_release", 32'(RUNNING), 0);

    // Start: RUNNING rises on the third edge after BTN rises.
    BTN = 1'b1;
    wait_n(1);                                   // P1
    check("start_p1_running", 32'(RUNNING), 0);
    wait_n(1);                                   // P2
    check("start_p2_running", 32'(RUNNING), 0);
    wait_n(1);                                   // P3
    check("start_p3_running", 32'(RUNNING), 1);
    check("start_p3_q", 32'(Q), 0);
    wait_n(2);                                   // P5
    BTN = 1'b0;
    wait_n(1);                                   // P6
    check("first_tick_before_q", 32'(Q), 0);
    wait_n(1);                                   // P7
    check("first_tick_q", 32'(Q), 1);
    check("held_btn_single_edge", 32'(RUNNING), 1);
    check("first_tick_carry", 32'(CARRY), 0);
    wait_n(4);                                   // P11
    check("second_tick_q", 32'(Q), 2);
    wait_n(28);                                  // P39
    check("reach_max_q", 32'(Q), 9);
    check("max_no_carry", 32'(CARRY), 0);
    wait_n(3);                                   // P42
    check("max_hold_q", 32'(Q), 9);
    wait_n(1);                                   // P43
    check("wrap_q", 32'(Q), 0);
    check("wrap_carry", 32'(CARRY), 1);
    wait_n(1);                                   // P44
    check("carry_one_cycle", 32'(CARRY), 0);

    // 400 running cycles hold exactly 10 wraps.
    carries = 0;
    for (int i = 0; i < 400; i++) begin
      wait_n(1);
      if (CARRY) carries++;
    end                                          // P444: Q=0, div=1
    check("carry_count_400", 32'(carries), 10);
    check("after_400_q", 32'(Q), 0);

    // Pause with the prescaler at 2, then resume.
    wait_n(3);                                   // P447 (tick)
    check("pre_pause_q", 32'(Q), 1);
    BTN = 1'b1;
    wait_n(2);                                   // P449, div=2
    check("pre_pause_running", 32'(RUNNING), 1);
    wait_n(1);                                   // P450, div=3 held
    check("pause_running", 32'(RUNNING), 0);
    check("pause_state", 32'(o_dbg_state), 2);
    wait_n(2);
    BTN = 1'b0;
    wait_n(20);                                  // P472
    check("pause_q_frozen", 32'(Q), 1);
    check("pause_still_paused", 32'(RUNNING), 0);
    BTN = 1'b1;
    wait_n(2);                                   // P474
    check("resume_p2_running", 32'(RUNNING), 0);
    wait_n(1);                                   // P475
    check("resume_running", 32'(RUNNING), 1);
    check("resume_q_unchanged", 32'(Q), 1);
    wait_n(1);                                   // P476: held phase ticks now
    check("resume_first_tick_q", 32'(Q), 2);
    BTN = 1'b0;
    wait_n(12);                                  // P488
    check("before_clr_q", 32'(Q), 5);

    // CLR together with an edge pulse: clear wins, edge is discarded.
    BTN = 1'b1;
    wait_n(2);                                   // P490, edge pulse live
    CLR = 1'b1;
    wait_n(1);                                   // P491
    CLR = 1'b0;
    BTN = 1'b0;
    check("clr_q", 32'(Q), 0);
    check("clr_running", 32'(RUNNING), 0);
    check("clr_state", 32'(o_dbg_state), 0);
    check("clr_carry", 32'(CARRY), 0);
    wait_n(5);                                   // P496
    check("clr_edge_dropped", 32'(RUNNING), 0);
    check("clr_q_stays", 32'(Q), 0);

    // Asynchronous reset mid-count at Q=7.
    BTN = 1'b1;
    wait_n(3);                                   // P499
    BTN = 1'b0;
    check("restart_running", 32'(RUNNING), 1);
    wait_n(28);                                  // P527
    check("midcount_q", 32'(Q), 7);
    wait_n(2);
    #2;
    XRST = 1'b0;
    #1;
    check("async_reset_q", 32'(Q), 0);
    check("async_reset_running", 32'(RUNNING), 0);
    check("async_reset_carry", 32'(CARRY), 0);

    // BTN already high at reset release, held for 100 cycles.
    BTN = 1'b1;
    wait_n(1);
    check("reset_held_q", 32'(Q), 0);
    XRST = 1'b1;
    rises     = 0;
    q_changes = 0;
    prev_run  = 1'b0;
    prev_q    = 4'd0;
    for (int i = 1; i <= 100; i++) begin
      wait_n(1);
      if (RUNNING && !prev_run) rises++;
      if (Q != prev_q) q_changes++;
      if (i == 2) check("held_p2_running", 32'(RUNNING), 0);
      if (i == 3) check("held_p3_running", 32'(RUNNING), 1);
      prev_run = RUNNING;
      prev_q   = Q;
    end
    BTN = 1'b0;
    check("held_run_rises", 32'(rises), 1);
    check("held_q_advances", 32'(q_changes), 24);
    check("held_final_q", 32'(Q), 4);
    check("held_final_running", 32'(RUNNING), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning clock cycles per count step; legal range 2..2^24.
REQ-002 The block SHALL have parameter MAX, default 9, meaning the terminal count value of Q; legal range 1..15.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: CLK  input  1  rising-edge clock; XRST  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port BTN  input  1  start/stop button, asynchronous to CLK, level-active-high.
REQ-005 The block SHALL have port CLR  input  1  synchronous clear, active-high, sampled on CLK.
REQ-006 The block SHALL have port Q  output  4  current count, 0..MAX, registered; it drives the 4-bit data input of the 7-seg decoder directly.
REQ-007 The block SHALL have port CARRY  output  1  one-cycle pulse on wrap MAX->0, registered.
REQ-008 The block SHALL have port RUNNING  output  1  high while the state machine is in RUN, registered.

Function
REQ-009 BTN SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; edge pulse asserts 3 CLK edges after BTN rises (2 sync stages + 1 edge register).
REQ-010 A BTN level held high for many cycles SHALL produce exactly one edge pulse.
REQ-011 The state machine SHALL have states IDLE, RUN, PAUSE.
REQ-012 On an edge pulse: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; with no edge pulse the state holds.
REQ-013 The prescaler div_cnt SHALL count 0..DIV-1 only in RUN, SHALL hold its value in PAUSE, and SHALL be 0 in IDLE.
REQ-014 A tick SHALL occur on the edge where state==RUN and div_cnt==DIV-1; on that edge div_cnt SHALL go to 0.
REQ-015 On a tick, Q SHALL become 0 if Q==MAX, else Q+1; Q SHALL therefore advance once every DIV cycles in RUN.
REQ-016 CARRY SHALL be 1 for exactly the one cycle following a tick with Q==MAX; otherwise 0.
REQ-017 A tick coinciding with a RUN->PAUSE edge pulse SHALL still be applied (Q advances; CARRY may pulse); the state then holds in PAUSE.
REQ-018 Re-entering RUN from PAUSE SHALL resume div_cnt from its held value (no phase loss).
REQ-019 CLR high SHALL, on that edge, set Q=0, div_cnt=0, CARRY=0 and state=IDLE, with priority over tick and edge pulse; an edge pulse coincident with CLR SHALL be discarded.
REQ-020 CLR SHALL NOT clear the synchronizer or edge-detector flops.
REQ-021 RUNNING SHALL reflect the state register (1 iff RUN) with no additional latency.
REQ-022 Width rule: div_cnt SHALL be $clog2(DIV) bits; Q arithmetic SHALL be 4-bit with no value above MAX ever produced.

Reset
REQ-023 XRST low SHALL asynchronously force Q=0, CARRY=0, RUNNING=0, state=IDLE, div_cnt=0, and all synchronizer and edge flops to 0.
REQ-024 Release of XRST SHALL take effect on the next CLK edge; a BTN already high at release SHALL generate one edge pulse (synchronizer flops reset to 0).
REQ-025 XRST asserted mid-count SHALL discard all progress; no CARRY pulse SHALL be emitted by the reset.

Verification (DIV=4, MAX=9)
REQ-026 Reset, BTN pulse high 5 cycles -> RUNNING=1 three edges after BTN rise; Q steps 0,1,2,... every 4 cycles.
REQ-027 Run to Q=9, next tick -> Q=0 and CARRY=1 for exactly one cycle; 10 CARRY pulses per 400 RUN cycles.
REQ-028 BTN pulse in RUN at div_cnt=2, wait 20 cycles, BTN pulse again -> Q frozen during PAUSE; first tick after resume comes 1 cycle after RUNNING returns high.
REQ-029 CLR asserted in RUN at Q=5 in the same cycle as an edge pulse -> next cycle Q=0, RUNNING=0, state IDLE (edge ignored).
REQ-030 XRST low for 1 cycle asynchronously mid-count at Q=7 -> Q=0, RUNNING=0, CARRY=0 immediately, before the next CLK edge.
REQ-031 BTN held high for 100 cycles from IDLE -> exactly one transition to RUN; Q advances 25 times in that window minus sync latency.
